// File: rtl/ctrl_pipeline_pkg.sv
// Shared types and encodings for the control pipeline: ALUop codes,
// forwarding selects and the per-stage control bundle.
package ctrl_pkg;

  localparam logic [1:0] ALUOP_IMM = 2'b00;
  localparam logic [1:0] ALUOP_MEM = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_BR  = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Control bits carried from ID down to WB. Register addresses are kept
  // beside the bundle because their width is a module parameter.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decoder-side inputs and datapath-side outputs of the control pipeline.
interface ctrl_pipeline_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [1:0]             id_alu_op;
  logic                   id_alu_src;
  logic                   id_branch;
  logic                   id_mem_read;
  logic                   id_mem_write;
  logic                   id_reg_write;
  logic                   id_mem_to_reg;
  logic [REG_ADDR_W-1:0]  id_rs1;
  logic [REG_ADDR_W-1:0]  id_rs2;
  logic [REG_ADDR_W-1:0]  id_rd;
  logic                   branch_taken;

  logic [1:0]             ex_alu_op;
  logic                   ex_alu_src;
  logic                   ex_branch;
  logic                   mem_mem_read;
  logic                   mem_mem_write;
  logic                   wb_reg_write;
  logic                   wb_mem_to_reg;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [1:0]             forward_a;
  logic [1:0]             forward_b;
  logic                   stall;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_rs1, id_rs2, id_rd, branch_taken,
    input  ex_alu_op, ex_alu_src, ex_branch, mem_mem_read, mem_mem_write,
           wb_reg_write, wb_mem_to_reg, wb_rd, forward_a, forward_b, stall, flush,
           stall_count
  );

  modport slave (
    input  id_valid, id_alu_op, id_alu_src, id_branch, id_mem_read, id_mem_write,
           id_reg_write, id_mem_to_reg, id_rs1, id_rs2, id_rd, branch_taken,
    output ex_alu_op, ex_alu_src, ex_branch, mem_mem_read, mem_mem_write,
           wb_reg_write, wb_mem_to_reg, wb_rd, forward_a, forward_b, stall, flush,
           stall_count
  );
endinterface

// File: rtl/ctrl_pipeline_hazard_forward_unit.sv
// Combinational hazard logic: load-use stall, branch flush and EX operand
// forwarding selects.
module hazard_forward_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  branch_taken,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
);

  // Nearest producer wins; x0 is hardwired zero so it never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs) return FWD_EXMEM;
    if (wb_reg_write && wb_rd != '0 && wb_rd == rs)    return FWD_MEMWB;
    return FWD_RF;
  endfunction

  logic load_use;

  // Flush squashes the ID instruction anyway, so it masks any stall.
  always_comb begin
    flush     = branch_taken & ex_branch;
    load_use  = ex_mem_read && ex_rd != '0 && id_valid &&
                (ex_rd == id_rs1 || ex_rd == id_rs2);
    stall     = load_use & ~flush;
    forward_a = fwd_sel(ex_rs1);
    forward_b = fwd_sel(ex_rs2);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, branch
// flush, forwarding selects and a saturating stall counter.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_pipeline_if.slave bus
);

  ctrl_bundle_t           ex_ctrl_q, ex_ctrl_d;
  ctrl_bundle_t           mem_ctrl_q, mem_ctrl_d;
  ctrl_bundle_t           wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0]  ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_W-1:0]  mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  ctrl_bundle_t           id_ctrl;
  logic                   stall, flush;

  hazard_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hfu (
    .id_valid      (bus.id_valid),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .ex_mem_read   (ex_ctrl_q.mem_read),
    .ex_branch     (ex_ctrl_q.branch),
    .ex_rd         (ex_rd_q),
    .ex_rs1        (ex_rs1_q),
    .ex_rs2        (ex_rs2_q),
    .branch_taken  (bus.branch_taken),
    .mem_reg_write (mem_ctrl_q.reg_write),
    .mem_rd        (mem_rd_q),
    .wb_reg_write  (wb_ctrl_q.reg_write),
    .wb_rd         (wb_rd_q),
    .stall         (stall),
    .flush         (flush),
    .forward_a     (bus.forward_a),
    .forward_b     (bus.forward_b)
  );

  // Decoder may leave MemToReg undefined when RegWrite=0; gating with RegWrite
  // keeps a clean 0 in the pipe.
  always_comb begin
    id_ctrl = '{alu_op:     bus.id_alu_op,
                alu_src:    bus.id_alu_src,
                branch:     bus.id_branch,
                mem_read:   bus.id_mem_read,
                mem_write:  bus.id_mem_write,
                reg_write:  bus.id_reg_write,
                mem_to_reg: bus.id_mem_to_reg & bus.id_reg_write};
  end

  // Next-state for all stages: flush/stall/invalid inject a bubble into EX,
  // later stages always advance; counter saturates at all-ones.
  always_comb begin
    ex_ctrl_d  = BUBBLE;
    ex_rd_d    = '0;
    ex_rs1_d   = '0;
    ex_rs2_d   = '0;
    if (!flush && !stall && bus.id_valid) begin
      ex_ctrl_d = id_ctrl;
      ex_rd_d   = bus.id_rd;
      ex_rs1_d  = bus.id_rs1;
      ex_rs2_d  = bus.id_rs2;
    end
    mem_ctrl_d    = ex_ctrl_q;
    mem_rd_d      = ex_rd_q;
    wb_ctrl_d     = mem_ctrl_q;
    wb_rd_d       = mem_rd_q;
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1)
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
  end

  // Stage registers; reset clears every in-flight bundle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl_q     <= BUBBLE;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      mem_ctrl_q    <= BUBBLE;
      mem_rd_q      <= '0;
      wb_ctrl_q     <= BUBBLE;
      wb_rd_q       <= '0;
      stall_count_q <= '0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_rd_q      <= mem_rd_d;
      wb_ctrl_q     <= wb_ctrl_d;
      wb_rd_q       <= wb_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_branch     = ex_ctrl_q.branch;
  assign bus.mem_mem_read  = mem_ctrl_q.mem_read;
  assign bus.mem_mem_write = mem_ctrl_q.mem_write;
  assign bus.wb_reg_write  = wb_ctrl_q.reg_write;
  assign bus.wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus a randomized run against
// an instruction-level pipeline model.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ctrl_pipeline_if #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) bus ();

  ctrl_pipeline #(.REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [22:0] all_outs;
  logic [16:0] reg_outs;
  assign all_outs = {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch, bus.mem_mem_read,
                     bus.mem_mem_write, bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd,
                     bus.forward_a, bus.forward_b, bus.stall, bus.flush, bus.stall_count};
  assign reg_outs = {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch, bus.mem_mem_read,
                     bus.mem_mem_write, bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd,
                     bus.stall_count};

  // Instruction record used by the reference model
  typedef struct {
    logic [1:0]    alu_op;
    logic          alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
    logic [AW-1:0] rd, rs1, rs2;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_cnt;

  function automatic ins_t empty_ins();
    ins_t r;
    r = '{alu_op: 2'b00, alu_src: 1'b0, branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
          reg_write: 1'b0, mem_to_reg: 1'b0, rd: '0, rs1: '0, rs2: '0};
    return r;
  endfunction

  function automatic logic [1:0] fwd_model(input logic [AW-1:0] rs);
    if (m_mem.reg_write && m_mem.rd != 0 && m_mem.rd == rs) return 2'b10;
    if (m_wb.reg_write && m_wb.rd != 0 && m_wb.rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic set_id(input logic v, input logic [1:0] op, input logic src, br, mr, mw,
                        rw, mtr, input logic [AW-1:0] rs1, rs2, rd);
    bus.id_valid = v;      bus.id_alu_op = op;     bus.id_alu_src = src;
    bus.id_branch = br;    bus.id_mem_read = mr;   bus.id_mem_write = mw;
    bus.id_reg_write = rw; bus.id_mem_to_reg = mtr;
    bus.id_rs1 = rs1;      bus.id_rs2 = rs2;       bus.id_rd = rd;
  endtask

  task automatic idle();
    set_id(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_state: got %h want 0", all_outs); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, AW'(i));
      tick();
    end
    checks++;
    if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd1) begin
      errors++; $display("FAIL reset_inflight: got wb_rd %0d want 1", bus.wb_rd);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", all_outs); end
    tick();
    checks++;
    if (all_outs !== '0 || $isunknown(all_outs)) begin
      errors++; $display("FAIL reset_hold: got %h want 0", all_outs);
    end
    reset = 1'b0;
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 6);
    tick();
    idle();
    checks++;
    if (bus.ex_alu_op !== ALUOP_R) begin errors++; $display("FAIL reset_release_ex: got %b want 10", bus.ex_alu_op); end
    tick(); tick();
    checks++;
    if (bus.wb_rd !== 5'd6 || bus.wb_reg_write !== 1'b1) begin
      errors++; $display("FAIL reset_release_wb: got rd %0d want 6", bus.wb_rd);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 5);
    tick();
    idle();
    checks++;
    if (bus.ex_alu_op !== 2'b10) begin errors++; $display("FAIL rtype_ex: got %b want 10", bus.ex_alu_op); end
    tick();
    checks++;
    if (bus.wb_reg_write !== 1'b0) begin errors++; $display("FAIL rtype_early_wb: got %b want 0", bus.wb_reg_write); end
    tick();
    checks++;
    if (bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd5) begin
      errors++; $display("FAIL rtype_wb: got we %b rd %0d want 1 5", bus.wb_reg_write, bus.wb_rd);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, ALUOP_MEM, 1, 0, 1, 0, 1, 1, 1, 0, 3);
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 3, 6, 7);
    #1;
    checks++;
    if ({bus.stall, bus.flush} !== 2'b10) begin errors++; $display("FAIL lu_stall: got %b want 10", {bus.stall, bus.flush}); end
    tick();
    checks++;
    if ({bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch} !== 4'b0 || bus.mem_mem_read !== 1'b1) begin
      errors++; $display("FAIL lu_bubble: got ex %b memrd %b want 0000 1",
                         {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch}, bus.mem_mem_read);
    end
    checks++;
    if (bus.stall_count !== 4'd1 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL lu_count: got cnt %0d stall %b want 1 0", bus.stall_count, bus.stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b00 || bus.ex_alu_op !== 2'b10) begin
      errors++; $display("FAIL lu_fwd: got fa %b fb %b op %b want 01 00 10", bus.forward_a, bus.forward_b, bus.ex_alu_op);
    end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 4);
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 8, 4, 9);
    tick();
    idle();
    #1;
    checks++;
    if (bus.forward_b !== 2'b10 || bus.forward_a !== 2'b00) begin
      errors++; $display("FAIL fwd_exmem: got fa %b fb %b want 00 10", bus.forward_a, bus.forward_b);
    end
    do_reset();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 0);
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 8, 0, 9);
    tick();
    idle();
    #1;
    checks++;
    if (bus.forward_b !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b want 00", bus.forward_b); end
    do_reset();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 4);
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 5, 6, 4);
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 4, 4, 9);
    tick();
    idle();
    #1;
    checks++;
    if ({bus.forward_a, bus.forward_b} !== 4'b1010) begin
      errors++; $display("FAIL fwd_priority: got %b want 1010", {bus.forward_a, bus.forward_b});
    end
    do_reset();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 1, 2, 4);
    tick();
    idle();
    tick();
    set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 4, 7, 9);
    tick();
    idle();
    #1;
    checks++;
    if ({bus.forward_a, bus.forward_b} !== 4'b0100) begin
      errors++; $display("FAIL fwd_memwb: got %b want 0100", {bus.forward_a, bus.forward_b});
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, ALUOP_BR, 0, 1, 1, 0, 0, 0, 1, 2, 3);
    tick();
    set_id(1, ALUOP_MEM, 1, 0, 1, 0, 1, 1, 3, 0, 5);
    #1;
    checks++;
    if ({bus.stall, bus.flush} !== 2'b10) begin errors++; $display("FAIL flush_not_taken: got %b want 10", {bus.stall, bus.flush}); end
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if ({bus.stall, bus.flush} !== 2'b01) begin errors++; $display("FAIL flush_prio: got %b want 01", {bus.stall, bus.flush}); end
    tick();
    idle();
    #1;
    checks++;
    if ({bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch} !== 4'b0 || bus.stall_count !== 4'd0) begin
      errors++; $display("FAIL flush_bubble: got ex %b cnt %0d want 0000 0",
                         {bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch}, bus.stall_count);
    end
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_qual: got %b want 0", bus.flush); end
    bus.branch_taken = 1'b0;
  endtask

  task automatic test_store();
    do_reset();
    set_id(1, ALUOP_MEM, 1, 0, 0, 1, 0, 1'bx, 2, 3, 0);
    tick();
    idle();
    checks++;
    if (bus.mem_mem_write !== 1'b0) begin errors++; $display("FAIL store_early: got %b want 0", bus.mem_mem_write); end
    tick();
    checks++;
    if (bus.mem_mem_write !== 1'b1) begin errors++; $display("FAIL store_mem: got %b want 1", bus.mem_mem_write); end
    tick();
    checks++;
    if (bus.wb_mem_to_reg !== 1'b0 || bus.wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL store_wb: got mtr %b we %b want 0 0", bus.wb_mem_to_reg, bus.wb_reg_write);
    end
  endtask

  task automatic test_saturate();
    int exp_cnt;
    do_reset();
    for (int n = 1; n <= 18; n++) begin
      set_id(1, ALUOP_MEM, 1, 0, 1, 0, 1, 1, 1, 0, 3);
      tick();
      set_id(1, ALUOP_R, 0, 0, 0, 0, 1, 0, 3, 2, 7);
      tick();
      idle();
      exp_cnt = (n > 15) ? 15 : n;
      checks++;
      if (bus.stall_count !== CW'(exp_cnt)) begin
        errors++; $display("FAIL sat_count: got %0d want %0d", bus.stall_count, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic          v, src, br, mr, mw, rw, mtr, bt, e_flush, e_stall;
    logic [1:0]    op, e_fa, e_fb;
    logic [AW-1:0] rs1, rs2, rd;
    logic [16:0]   e_reg;
    do_reset();
    m_ex = empty_ins(); m_mem = empty_ins(); m_wb = empty_ins(); m_cnt = 0;
    repeat (400) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom);
      src = 1'($urandom); br = ($urandom_range(0, 3) == 0);
      mr  = 1'($urandom); mw = 1'($urandom); rw = 1'($urandom);
      mtr = rw ? 1'($urandom) : (($urandom_range(0, 1) == 1) ? 1'bx : 1'b0);
      rs1 = AW'($urandom_range(0, 3)); rs2 = AW'($urandom_range(0, 3));
      rd  = AW'($urandom_range(0, 3));
      bt  = 1'($urandom);
      set_id(v, op, src, br, mr, mw, rw, mtr, rs1, rs2, rd);
      bus.branch_taken = bt;
      #1;
      e_flush = bt && m_ex.branch;
      e_stall = !e_flush && v && m_ex.mem_read && m_ex.rd != 0 && (m_ex.rd == rs1 || m_ex.rd == rs2);
      e_fa    = fwd_model(m_ex.rs1);
      e_fb    = fwd_model(m_ex.rs2);
      e_reg   = {m_ex.alu_op, m_ex.alu_src, m_ex.branch, m_mem.mem_read, m_mem.mem_write,
                 m_wb.reg_write, m_wb.mem_to_reg, m_wb.rd, CW'(m_cnt)};
      checks++;
      if ({bus.stall, bus.flush, bus.forward_a, bus.forward_b} !== {e_stall, e_flush, e_fa, e_fb}) begin
        errors++; $display("FAIL rand_hazard: got %b want %b",
                           {bus.stall, bus.flush, bus.forward_a, bus.forward_b}, {e_stall, e_flush, e_fa, e_fb});
      end
      checks++;
      if (reg_outs !== e_reg) begin errors++; $display("FAIL rand_stages: got %h want %h", reg_outs, e_reg); end
      @(posedge clk);
      m_wb  = m_mem;
      m_mem = m_ex;
      if (e_flush || e_stall || !v) m_ex = empty_ins();
      else m_ex = '{alu_op: op, alu_src: src, branch: br, mem_read: mr, mem_write: mw,
                    reg_write: rw, mem_to_reg: rw ? mtr : 1'b0, rd: rd, rs1: rs1, rs2: rs2};
      if (e_stall && m_cnt < 15) m_cnt++;
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_forward();
    test_flush();
    test_store();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
